// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: D/E/M/W decode, stall/flush and forwarding selects.
// Optional HAZ_MDU_EN adds the multiply/divide busy counter and its stall.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] InstrE,
  input  logic [31:0] InstrM,
  input  logic [31:0] InstrW,
  output logic        Stall,
  output logic        FlushE,
  output logic [1:0]  ForwardRSD,
  output logic [1:0]  ForwardRTD,
  output logic [1:0]  ForwardRSE,
  output logic [1:0]  ForwardRTE,
  output logic        ForwardRTM,
  output logic        MDBusy
);

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] wr;
    logic       link;
    logic [1:0] tnew_e;
    logic [1:0] tnew_m;
    logic       use_rs;
    logic       use_rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       md;
    logic       md_div;
    logic       mf;
    logic       mt;
    logic       mtc0;
    logic       eret;
    logic       store;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] fn;
    logic       cal_r, cal_i, load, br2, branch, jr, jalr, jal, bgezal, mfc0;
    op = instr[31:26];
    fn = instr[5:0];
    d = '0;
    d.rs = instr[25:21];
    d.rt = instr[20:16];
    d.rd = instr[15:11];

    cal_r  = (op == 6'h00) && (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                         6'h26, 6'h27, 6'h2a, 6'h2b});
    jr     = (op == 6'h00) && (fn == 6'h08);
    jalr   = (op == 6'h00) && (fn == 6'h09);
    d.mf   = (op == 6'h00) && (fn inside {6'h10, 6'h12});
    d.mt   = (op == 6'h00) && (fn inside {6'h11, 6'h13});
    d.md   = (op == 6'h00) && (fn inside {6'h18, 6'h19, 6'h1a, 6'h1b});
    d.md_div = d.md && fn[1];
    cal_i  = op inside {6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    load   = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    d.store = op inside {6'h28, 6'h29, 6'h2b};
    br2    = op inside {6'h04, 6'h05};
    bgezal = (op == 6'h01) && (d.rt == 5'h11);
    branch = br2 || (op inside {6'h06, 6'h07}) ||
             ((op == 6'h01) && (d.rt inside {5'h00, 5'h01, 5'h11}));
    jal    = (op == 6'h03);
    mfc0   = (op == 6'h10) && (d.rs == 5'h00);
    d.mtc0 = (op == 6'h10) && (d.rs == 5'h04);
    d.eret = (op == 6'h10) && (d.rs == 5'h10) && (fn == 6'h18);

    if (cal_r || jalr || d.mf)      d.wr = d.rd;
    else if (cal_i || load || mfc0) d.wr = d.rt;
    else if (jal || bgezal)         d.wr = 5'd31;
    d.link = jal || jalr || bgezal;

    if (load || mfc0)                d.tnew_e = 2'd2;
    else if (cal_r || cal_i || d.mf) d.tnew_e = 2'd1;
    d.tnew_m = (load || mfc0) ? 2'd1 : 2'd0;

    // Only beq/bne read rt; the regimm rt field is a sub-opcode, not a register.
    if (branch || jr || jalr) begin
      d.use_rs = 1'b1;
      d.use_rt = br2;
    end else if (cal_r || d.md) begin
      d.use_rs  = 1'b1;
      d.use_rt  = 1'b1;
      d.tuse_rs = 2'd1;
      d.tuse_rt = 2'd1;
    end else if (cal_i || load || d.store || d.mt) begin
      d.use_rs  = 1'b1;
      d.tuse_rs = 2'd1;
      d.use_rt  = d.store;
      d.tuse_rt = 2'd2;
    end else if (d.mtc0) begin
      d.use_rt  = 1'b1;
      d.tuse_rt = 2'd2;
    end
    return d;
  endfunction

  // A Tuse 0 source cannot take an E-stage value at all, so any E match stalls.
  function automatic logic src_stall(input logic used, input logic [4:0] r,
                                     input logic [1:0] tuse, input dec_t e, input dec_t m);
    return used && (r != 5'd0) &&
           (((r == e.wr) && ((tuse == 2'd0) || (e.tnew_e > tuse))) ||
            ((r == m.wr) && (m.tnew_m > tuse)));
  endfunction

  function automatic logic [1:0] fwd_m(input logic used, input logic [4:0] r, input dec_t m);
    if (used && (r != 5'd0) && (r == m.wr) && (m.tnew_m == 2'd0))
      return m.link ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] fwd_e(input logic used, input logic [4:0] r,
                                       input dec_t m, input dec_t w);
    logic [1:0] sel;
    sel = fwd_m(used, r, m);
    if ((sel == 2'b00) && used && (r != 5'd0) && (r == w.wr))
      sel = 2'b11;
    return sel;
  endfunction

  dec_t d_d, d_e, d_m, d_w;
  logic data_stall, eret_stall, md_stall;
  logic unused_sink;

  always_comb begin
    d_d = decode(InstrD);
    d_e = decode(InstrE);
    d_m = decode(InstrM);
    d_w = decode(InstrW);
  end

  always_comb begin
    data_stall = src_stall(d_d.use_rs, d_d.rs, d_d.tuse_rs, d_e, d_m) ||
                 src_stall(d_d.use_rt, d_d.rt, d_d.tuse_rt, d_e, d_m);
    eret_stall = d_d.eret && ((d_e.mtc0 && (d_e.rd == 5'd14)) ||
                              (d_m.mtc0 && (d_m.rd == 5'd14)));
    ForwardRSD = fwd_m(d_d.use_rs, d_d.rs, d_m);
    ForwardRTD = fwd_m(d_d.use_rt, d_d.rt, d_m);
    ForwardRSE = fwd_e(d_e.use_rs, d_e.rs, d_m, d_w);
    ForwardRTE = fwd_e(d_e.use_rt, d_e.rt, d_m, d_w);
    ForwardRTM = d_m.store && (d_m.rt != 5'd0) && (d_m.rt == d_w.wr);
  end

`ifdef HAZ_MDU_EN
  logic [3:0] md_cnt;

  // A new md in E reloads even while counting; the load beats the decrement.
  always_ff @(posedge clk) begin
    if (reset)                md_cnt <= '0;
    else if (d_e.md)          md_cnt <= d_e.md_div ? 4'd10 : 4'd5;
    else if (md_cnt != 4'd0)  md_cnt <= md_cnt - 4'd1;
  end

  always_comb begin
    MDBusy      = (md_cnt != 4'd0) || d_e.md;
    unused_sink = ^{d_d, d_e, d_m, d_w};
  end
`else
  always_comb begin
    MDBusy      = 1'b0;
    unused_sink = ^{clk, reset, d_d, d_e, d_m, d_w};
  end
`endif

  always_comb begin
    md_stall = (d_d.md || d_d.mf || d_d.mt) && MDBusy;
    Stall    = data_stall || eret_stall || md_stall;
    FlushE   = Stall;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus MDU/reset sequences via a scoreboard queue.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD, InstrE, InstrM, InstrW;
  logic        Stall, FlushE, ForwardRTM, MDBusy;
  logic [1:0]  ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .InstrD(InstrD), .InstrE(InstrE), .InstrM(InstrM), .InstrW(InstrW),
    .Stall(Stall), .FlushE(FlushE),
    .ForwardRSD(ForwardRSD), .ForwardRTD(ForwardRTD),
    .ForwardRSE(ForwardRSE), .ForwardRTE(ForwardRTE),
    .ForwardRTM(ForwardRTM), .MDBusy(MDBusy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic [1:0] frsd;
    logic [1:0] frtd;
    logic [1:0] frse;
    logic [1:0] frte;
    logic       frtm;
    logic       busy;
  } outs_t;

  typedef struct {
    logic [31:0] d, e, m, w;
    outs_t       exp;
  } vec_t;

  outs_t sb_q[$];
  vec_t  vt[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic outs_t mk(input logic s, input logic [1:0] frsd, input logic [1:0] frtd,
                               input logic [1:0] frse, input logic [1:0] frte,
                               input logic frtm, input logic busy);
    outs_t o;
    o.stall = s;    o.flush = s;
    o.frsd  = frsd; o.frtd  = frtd;
    o.frse  = frse; o.frte  = frte;
    o.frtm  = frtm; o.busy  = busy;
    return o;
  endfunction

  task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                       input logic [31:0] w, input outs_t exp);
    @(negedge clk);
    InstrD = d; InstrE = e; InstrM = m; InstrW = w;
    sb_q.push_back(exp);
  endtask

  task automatic check(input string name);
    outs_t act, exp;
    #2;
    act = {Stall, FlushE, ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, ForwardRTM, MDBusy};
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got %b", name, act);
    end else begin
      exp = sb_q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s: got {stall,flush,rsd,rtd,rse,rte,rtm,busy}=%b required %b",
                 name, act, exp);
      end
    end
  endtask

  logic [31:0] nop, lw1, beq12, addu3, beq30, jal, jr31, addu6, subu766, addu0, subu700;
  logic [31:0] lw8, sw8, mtc0_14, mtc0_12, eret, addu10_12, addu1, sw1, addu5_12, addu2;
  logic [31:0] subu_31, beq00, lw0, addu10_34, lw3, mflo, mult, div;

  // Steps a flow of mflo waiting in D behind one md in E; E becomes a bubble while stalled.
  task automatic run_mdu(input logic [31:0] mdi, input int load, input int want, input string name);
    int   cnt_m;
    int   stalls;
    logic busy;
    logic [31:0] e;
    cnt_m = 0;
    stalls = 0;
    for (int c = 0; c < 16; c++) begin
      e = (c == 0) ? mdi : nop;
`ifdef HAZ_MDU_EN
      busy = (cnt_m != 0) || (c == 0);
`else
      busy = 1'b0;
`endif
      drive(mflo, e, nop, nop, mk(busy, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, busy));
      check($sformatf("%s_c%0d", name, c));
      if (Stall === 1'b1) stalls++;
      if (c == 0) cnt_m = load;
      else if (cnt_m != 0) cnt_m--;
    end
    n_vec++;
    if (stalls != want) begin
      n_err++;
      $display("FAIL %s_stall_cycles: got %0d required %0d", name, stalls, want);
    end
  endtask

  initial begin
    outs_t z;
    logic  mdu;
`ifdef HAZ_MDU_EN
    mdu = 1'b1;
`else
    mdu = 1'b0;
`endif
    z = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    nop       = '0;
    lw1       = itype(6'h23, 5'd0, 5'd1, 16'd0);
    beq12     = itype(6'h04, 5'd1, 5'd2, 16'd4);
    addu3     = rtype(5'd4, 5'd5, 5'd3, 6'h21);
    beq30     = itype(6'h04, 5'd3, 5'd0, 16'd4);
    jal       = {6'h03, 26'h0000100};
    jr31      = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    addu6     = rtype(5'd1, 5'd2, 5'd6, 6'h21);
    subu766   = rtype(5'd6, 5'd6, 5'd7, 6'h23);
    addu0     = rtype(5'd1, 5'd2, 5'd0, 6'h21);
    subu700   = rtype(5'd0, 5'd0, 5'd7, 6'h23);
    lw8       = itype(6'h23, 5'd10, 5'd8, 16'd4);
    sw8       = itype(6'h2b, 5'd9, 5'd8, 16'd0);
    mtc0_14   = {6'h10, 5'h04, 5'd5, 5'd14, 11'd0};
    mtc0_12   = {6'h10, 5'h04, 5'd5, 5'd12, 11'd0};
    eret      = 32'h42000018;
    addu10_12 = rtype(5'd1, 5'd2, 5'd10, 6'h21);
    addu1     = rtype(5'd4, 5'd5, 5'd1, 6'h21);
    sw1       = itype(6'h2b, 5'd2, 5'd1, 16'd0);
    addu5_12  = rtype(5'd1, 5'd2, 5'd5, 6'h21);
    addu2     = rtype(5'd4, 5'd5, 5'd2, 6'h21);
    subu_31   = rtype(5'd31, 5'd0, 5'd7, 6'h23);
    beq00     = itype(6'h04, 5'd0, 5'd0, 16'd4);
    lw0       = itype(6'h23, 5'd1, 5'd0, 16'd0);
    addu10_34 = rtype(5'd3, 5'd4, 5'd10, 6'h21);
    lw3       = itype(6'h23, 5'd0, 5'd3, 16'd0);
    mflo      = rtype(5'd0, 5'd0, 5'd11, 6'h12);
    mult      = rtype(5'd1, 5'd2, 5'd0, 6'h18);
    div       = rtype(5'd1, 5'd2, 5'd0, 6'h1a);

    vt.push_back('{beq12, lw1, nop, nop, mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)});
    vt.push_back('{beq12, nop, lw1, nop, mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)});
    vt.push_back('{beq12, nop, nop, lw1, z});
    vt.push_back('{beq30, nop, addu3, nop, mk(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)});
    vt.push_back('{jr31, nop, jal, nop, mk(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)});
    vt.push_back('{nop, subu766, nop, addu6, mk(1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b0)});
    vt.push_back('{nop, subu700, nop, addu0, z});
    vt.push_back('{nop, nop, sw8, lw8, mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0)});
    vt.push_back('{eret, mtc0_14, nop, nop, mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)});
    vt.push_back('{eret, mtc0_12, nop, nop, z});
    vt.push_back('{eret, nop, mtc0_14, nop, mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)});
    vt.push_back('{addu10_12, lw1, nop, nop, mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)});
    vt.push_back('{addu10_12, addu1, nop, nop, z});
    vt.push_back('{sw1, lw1, nop, nop, z});
    vt.push_back('{jr31, jal, nop, nop, mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)});
    vt.push_back('{nop, addu5_12, addu1, addu2, mk(1'b0, 2'b00, 2'b00, 2'b01, 2'b11, 1'b0, 1'b0)});
    vt.push_back('{nop, subu_31, jal, nop, mk(1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0)});
    vt.push_back('{beq00, lw0, nop, nop, z});
    vt.push_back('{addu10_34, nop, lw3, nop, z});
    vt.push_back('{mflo, nop, nop, nop, z});

    reset = 1'b1;
    InstrD = nop; InstrE = nop; InstrM = nop; InstrW = nop;
    @(posedge clk);
    drive(nop, nop, nop, nop, z);
    check("reset_state");
    reset = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].d, vt[i].e, vt[i].m, vt[i].w, vt[i].exp);
      check($sformatf("vec%0d", i));
    end

    run_mdu(mult, 5, mdu ? 6 : 0, "mult");
    run_mdu(div, 10, mdu ? 11 : 0, "div");

    drive(mflo, div, nop, nop, mk(mdu, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, mdu));
    check("rst_div_in_e");
    drive(mflo, nop, nop, nop, mk(mdu, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, mdu));
    check("rst_counting");
    drive(mflo, nop, nop, nop, mk(mdu, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, mdu));
    reset = 1'b1;
    check("rst_asserted");
    drive(mflo, nop, nop, nop, z);
    reset = 1'b0;
    check("rst_cleared");
    drive(mflo, nop, nop, nop, z);
    check("rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
